// File: rtl/nms_frame_sequencer.sv
// Frame controller around the 3x3 NMS stage: pixel sequencing, flush
// padding, corner forwarding with a per-frame cap, and done/status.
module nms_frame_sequencer #(
  parameter int SCORE_W       = 8,
  parameter int MAX_W         = 2048,
  parameter int FLUSH_PIX     = 4,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [15:0]        cfg_w,
  input  logic [15:0]        cfg_h,
  input  logic [15:0]        cfg_max_corn,
  output logic               busy,
  output logic               done_irq,
  output logic               err_cfg,
  output logic               err_timeout,
  output logic [15:0]        corner_cnt,
  output logic [15:0]        drop_cnt,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [SCORE_W-1:0] up_score,
  input  logic               up_strong,
  output logic               n_valid,
  input  logic               n_ready,
  output logic [15:0]        n_x,
  output logic [15:0]        n_y,
  output logic [SCORE_W-1:0] n_score,
  output logic               n_strong,
  output logic               n_sof,
  output logic [15:0]        n_frm_w,
  output logic [15:0]        n_frm_h,
  input  logic               c_valid,
  output logic               c_ready,
  input  logic [15:0]        c_x,
  input  logic [15:0]        c_y,
  input  logic [SCORE_W-1:0] c_score,
  input  logic               c_strong,
  input  logic               c_tlast,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [32+SCORE_W:0] o_data,
  output logic               o_last
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int DW = 33 + SCORE_W;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_FLUSH, S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [15:0]   w_q, w_d, h_q, h_d;
  logic [15:0]   cap_q, cap_d;
  logic [15:0]   x_q, x_d, y_q, y_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   cc_q, cc_d, dc_q, dc_d;
  logic          errc_q, errc_d;
  logic          errt_q, errt_d;
  logic          done_q, done_d;
  logic          ov_q, ov_d, ol_q, ol_d;
  logic [DW-1:0] od_q, od_d;

  logic cfg_ok, start_ok, start_bad;
  logic n_hs, c_hs, o_hs, tlast_done;
  logic x_end, y_end, flush_end, tmo_end;
  logic cap_hit;

  assign cfg_ok = (cfg_w >= 16'd3) && (cfg_w <= 16'(MAX_W))
               && (cfg_h >= 16'd3);
  assign start_ok  = (state_q == S_IDLE) && cfg_start && cfg_ok;
  assign start_bad = (state_q == S_IDLE) && cfg_start && !cfg_ok;

  assign n_hs = n_valid & n_ready;
  assign c_hs = c_valid & c_ready & (state_q != S_IDLE);
  assign o_hs = ov_q & o_ready;
  assign tlast_done = o_hs & ol_q;

  assign x_end     = x_q == (w_q - 16'd1);
  assign y_end     = y_q == (h_q - 16'd1);
  assign flush_end = x_q == 16'(FLUSH_PIX - 1);
  assign tmo_end   = tmo_q == TW'(DRAIN_TIMEOUT - 1);
  assign cap_hit   = (cap_q != 16'd0) && (cc_q >= cap_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (n_hs && x_end && y_end) state_d = S_FLUSH;
      S_FLUSH: if (n_hs && flush_end) state_d = S_DRAIN;
      S_DRAIN: if (tlast_done || tmo_end) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b1;
    n_valid  = 1'b0;
    up_ready = 1'b0;
    n_score  = '0;
    n_strong = 1'b0;
    n_sof    = 1'b0;
    c_ready  = ~ov_q | o_ready;
    unique case (state_q)
      S_IDLE: begin
        busy    = 1'b0;
        c_ready = 1'b1;
      end
      S_RUN: begin
        n_valid  = up_valid;
        up_ready = n_ready;
        n_score  = up_score;
        n_strong = up_strong;
        n_sof    = (x_q == 16'd0) && (y_q == 16'd0);
      end
      S_FLUSH: n_valid = 1'b1;
      default: ;
    endcase
  end

  // Flush pixels reuse x; y has already wrapped to h, outside the window.
  always_comb begin
    w_d    = w_q;
    h_d    = h_q;
    cap_d  = cap_q;
    x_d    = x_q;
    y_d    = y_q;
    cc_d   = cc_q;
    dc_d   = dc_q;
    errc_d = errc_q;
    errt_d = errt_q;
    done_d = 1'b0;
    ov_d   = ov_q;
    ol_d   = ol_q;
    od_d   = od_q;
    tmo_d  = (state_q == S_DRAIN) ? tmo_q + TW'(1) : '0;
    if (start_ok) begin
      w_d    = cfg_w;
      h_d    = cfg_h;
      cap_d  = cfg_max_corn;
      x_d    = '0;
      y_d    = '0;
      cc_d   = '0;
      dc_d   = '0;
      errc_d = 1'b0;
      errt_d = 1'b0;
    end
    if (start_bad) begin
      errc_d = 1'b1;
      done_d = 1'b1;
    end
    if (n_hs) begin
      if (state_q == S_RUN && x_end) begin
        x_d = '0;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
    if (state_q == S_DRAIN && state_d == S_IDLE) begin
      done_d = 1'b1;
      if (!tlast_done) errt_d = 1'b1;
    end
    if (o_hs) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end
    if (c_hs) begin
      if (!c_tlast && cap_hit) begin
        dc_d = dc_q + {15'd0, dc_q != 16'hFFFF};
      end else begin
        ov_d = 1'b1;
        ol_d = c_tlast;
        od_d = {c_strong, c_score, c_y, c_x};
        if (!c_tlast || c_score != '0)
          cc_d = cc_q + {15'd0, cc_q != 16'hFFFF};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      h_q    <= '0;
      cap_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      tmo_q  <= '0;
      cc_q   <= '0;
      dc_q   <= '0;
      errc_q <= 1'b0;
      errt_q <= 1'b0;
      done_q <= 1'b0;
      ov_q   <= 1'b0;
      ol_q   <= 1'b0;
      od_q   <= '0;
    end else begin
      w_q    <= w_d;
      h_q    <= h_d;
      cap_q  <= cap_d;
      x_q    <= x_d;
      y_q    <= y_d;
      tmo_q  <= tmo_d;
      cc_q   <= cc_d;
      dc_q   <= dc_d;
      errc_q <= errc_d;
      errt_q <= errt_d;
      done_q <= done_d;
      ov_q   <= ov_d;
      ol_q   <= ol_d;
      od_q   <= od_d;
    end
  end

  assign n_x         = x_q;
  assign n_y         = y_q;
  assign n_frm_w     = w_q;
  assign n_frm_h     = h_q;
  assign corner_cnt  = cc_q;
  assign drop_cnt    = dc_q;
  assign err_cfg     = errc_q;
  assign err_timeout = errt_q;
  assign done_irq    = done_q;
  assign o_valid     = ov_q;
  assign o_last      = ol_q;
  assign o_data      = od_q;

endmodule

// File: tb/tb_nms_frame_sequencer.sv
// Randomized bench for nms_frame_sequencer; the bench plays the NMS stage
// and checks pixel/corner streams against a frame-level model.
module tb_nms_frame_sequencer;
  localparam int SW = 8;
  localparam int FP = 4;
  localparam int DT = 4096;
  localparam int OW = 33 + SW;

  logic          clk = 0, rst_n = 0;
  logic          cfg_start = 0;
  logic [15:0]   cfg_w = 0, cfg_h = 0, cfg_max_corn = 0;
  logic          busy, done_irq, err_cfg, err_timeout;
  logic [15:0]   corner_cnt, drop_cnt;
  logic          up_valid = 0, up_ready;
  logic [SW-1:0] up_score = 0;
  logic          up_strong = 0;
  logic          n_valid, n_ready = 0;
  logic [15:0]   n_x, n_y, n_frm_w, n_frm_h;
  logic [SW-1:0] n_score;
  logic          n_strong, n_sof;
  logic          c_valid = 0, c_ready;
  logic [15:0]   c_x = 0, c_y = 0;
  logic [SW-1:0] c_score = 0;
  logic          c_strong = 0, c_tlast = 0;
  logic          o_valid, o_ready = 0, o_last;
  logic [OW-1:0] o_data;

  nms_frame_sequencer #(
    .SCORE_W(SW), .MAX_W(2048), .FLUSH_PIX(FP), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_max_corn(cfg_max_corn),
    .busy(busy), .done_irq(done_irq), .err_cfg(err_cfg),
    .err_timeout(err_timeout),
    .corner_cnt(corner_cnt), .drop_cnt(drop_cnt),
    .up_valid(up_valid), .up_ready(up_ready),
    .up_score(up_score), .up_strong(up_strong),
    .n_valid(n_valid), .n_ready(n_ready), .n_x(n_x), .n_y(n_y),
    .n_score(n_score), .n_strong(n_strong), .n_sof(n_sof),
    .n_frm_w(n_frm_w), .n_frm_h(n_frm_h),
    .c_valid(c_valid), .c_ready(c_ready), .c_x(c_x), .c_y(c_y),
    .c_score(c_score), .c_strong(c_strong), .c_tlast(c_tlast),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_last(o_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  typedef struct {
    logic [15:0]   x;
    logic [15:0]   y;
    logic [SW-1:0] s;
    logic          st;
  } corn_t;
  corn_t cq[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_c(input int x, input int y, input int s, input bit st);
    corn_t c;
    c.x = 16'(x); c.y = 16'(y); c.s = SW'(s); c.st = st;
    cq.push_back(c);
  endtask

  task automatic rand_corners(input int n, input int w, input int h);
    cq.delete();
    for (int i = 0; i < n; i++)
      add_c($urandom_range(w - 1), $urandom_range(h - 1),
            $urandom_range(255, 1), 1'($urandom));
  endtask

  task automatic start(input int w, input int h, input int cap);
    @(posedge clk); #1;
    cfg_w = 16'(w); cfg_h = 16'(h); cfg_max_corn = 16'(cap);
    cfg_start = 1;
    @(posedge clk); #1;
    cfg_start = 0;
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_flags"},
        {busy, n_valid, o_valid, o_last, done_irq, err_cfg,
         err_timeout, n_sof, up_ready}, 0);
    chk({tag, "_cnt"}, {corner_cnt, drop_cnt}, 0);
    chk({tag, "_xy"}, {n_x, n_y}, 0);
    chk({tag, "_frm"}, {n_frm_w, n_frm_h}, 0);
  endtask

  // One frame: pixels in, NMS role played from cq, tlast after flush.
  task automatic run_frame(input int w, input int h, input int cap,
                           input bit thr, input bit zero, input bit hold,
                           input int pk, input logic [SW-1:0] tls);
    logic [SW-1:0] sc[];
    logic          stv[];
    logic [OW:0]   exp_o[$];
    int npix, ntot, nb, nf, ncorn, ecc, d;
    int flush_cyc, olast_cyc, done_cyc;
    bit stop;
    npix = w * h; ntot = npix + FP; nb = 0; stop = 0;
    flush_cyc = -1; olast_cyc = -1; done_cyc = -1;
    ncorn = cq.size();
    sc = new[npix]; stv = new[npix];
    for (int i = 0; i < npix; i++) begin
      sc[i]  = zero ? '0 : SW'($urandom);
      stv[i] = 1'($urandom);
    end
    if (pk >= 0) sc[pk] = SW'(9);
    nf = (cap == 0 || ncorn < cap) ? ncorn : cap;
    for (int i = 0; i < nf; i++)
      exp_o.push_back({1'b0, cq[i].st, cq[i].s, cq[i].y, cq[i].x});
    if (!hold) exp_o.push_back({1'b1, 1'b0, tls, 16'(h), 16'd0});
    ecc = nf + ((!hold && tls != 0) ? 1 : 0);

    start(w, h, cap);
    chk("start_stat", {busy, err_cfg, err_timeout}, 3'b100);
    chk("start_frm", {n_frm_w, n_frm_h}, {16'(w), 16'(h)});
    chk("start_cnt", {corner_cnt, drop_cnt}, 0);

    fork
      begin
        fork
          begin
            int i;
            bit hs;
            i = 0;
            while (i < npix) begin
              up_valid  = thr ? 1'($urandom) : 1'b1;
              up_score  = sc[i];
              up_strong = stv[i];
              @(negedge clk); hs = up_valid && up_ready;
              @(posedge clk); #1;
              if (hs) i++;
            end
            up_valid = 0;
          end
          begin
            bit hs;
            for (int k = 0; k < ncorn; k++) begin
              if (thr) repeat ($urandom_range(2)) begin
                @(posedge clk); #1;
              end
              c_valid = 1; c_tlast = 0;
              c_x = cq[k].x; c_y = cq[k].y;
              c_score = cq[k].s; c_strong = cq[k].st;
              hs = 0;
              while (!hs) begin
                @(negedge clk); hs = c_ready;
                @(posedge clk); #1;
              end
              c_valid = 0;
            end
            while (nb < ntot) begin
              @(posedge clk); #1;
            end
            if (!hold) begin
              c_valid = 1; c_tlast = 1;
              c_x = 0; c_y = 16'(h); c_score = tls; c_strong = 0;
              hs = 0;
              while (!hs) begin
                @(negedge clk); hs = c_ready;
                @(posedge clk); #1;
              end
              c_valid = 0; c_tlast = 0;
            end
          end
        join
        for (int k = 0; k < DT + 200 && done_cyc < 0; k++) begin
          @(negedge clk);
          if (done_irq) done_cyc = cyc;
        end
        stop = 1;
      end
      begin
        logic [63:0] e;
        while (!stop) begin
          @(posedge clk); #1;
          n_ready = thr ? 1'($urandom) : 1'b1;
          @(negedge clk);
          if (n_valid && n_ready) begin
            if (nb >= ntot) chk("n_count", nb + 1, ntot);
            if (nb < npix)
              e = {(nb == 0), stv[nb], sc[nb], 16'(nb / w), 16'(nb % w)};
            else
              e = {1'b0, 1'b0, SW'(0), 16'(h), 16'(nb - npix)};
            chk("n_beat", {n_sof, n_strong, n_score, n_y, n_x}, e);
            nb++;
            if (nb == ntot) flush_cyc = cyc;
          end
        end
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          o_ready = thr ? 1'($urandom) : 1'b1;
          @(negedge clk);
          if (o_valid && o_ready) begin
            if (exp_o.size() == 0) begin
              chk("o_extra", {o_last, o_data}, 0);
            end else begin
              chk("o_beat", {o_last, o_data}, exp_o.pop_front());
              if (o_last) olast_cyc = cyc;
            end
          end
        end
      end
    join
    n_ready = 0; o_ready = 0;

    chk("n_total", nb, ntot);
    chk("o_left", exp_o.size(), 0);
    chk("done_seen", done_cyc >= 0, 1);
    if (hold) begin
      d = done_cyc - flush_cyc;
      chk("tmo_lat", (d >= DT && d <= DT + 2), 1);
    end else begin
      chk("done_lat", done_cyc - olast_cyc, 1);
    end
    chk("err_to", err_timeout, hold);
    chk("cnt", {corner_cnt, drop_cnt}, {16'(ecc), 16'(ncorn - nf)});
    @(negedge clk);
    chk("done_pulse", {done_irq, busy}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic nv;
    repeat (2) @(posedge clk);
    #1 rst_chk("init");
    @(posedge clk); #1 rst_n = 1;

    cq.delete();
    run_frame(4, 4, 0, 0, 1, 0, -1, 0);

    cq.delete(); add_c(2, 2, 9, 1);
    run_frame(5, 5, 0, 0, 1, 0, 12, 0);

    rand_corners(5, 6, 4);
    run_frame(6, 4, 2, 0, 0, 0, -1, 0);

    @(posedge clk); #1;
    cfg_w = 2; cfg_h = 4; cfg_start = 1;
    @(posedge clk); #1 cfg_start = 0;
    chk("bad_stat", {err_cfg, busy, done_irq}, 3'b101);
    @(posedge clk); #1;
    chk("bad_pulse", done_irq, 0);
    nv = 0;
    repeat (8) begin
      @(negedge clk); nv |= n_valid;
    end
    chk("bad_nvalid", {nv, err_cfg}, 2'b01);
    rand_corners(2, 8, 4);
    run_frame(8, 4, 0, 0, 0, 0, -1, 8'd0);

    cq.delete(); add_c(1, 1, 3, 0);
    run_frame(3, 3, 0, 0, 0, 1, -1, 0);

    rand_corners(6, 16, 8);
    run_frame(16, 8, 0, 0, 0, 0, -1, 0);
    run_frame(16, 8, 0, 1, 0, 0, -1, 0);

    for (int f = 0; f < 4; f++) begin
      int w, h;
      w = $urandom_range(12, 3); h = $urandom_range(6, 3);
      rand_corners($urandom_range(6), w, h);
      run_frame(w, h, $urandom_range(4), 1'($urandom), 0, 0, -1,
                ($urandom % 2) ? SW'($urandom_range(255, 1)) : '0);
    end

    cq.delete();
    start(16, 8, 0);
    up_valid = 1; up_score = 5; n_ready = 1; o_ready = 0;
    c_valid = 1; c_x = 1; c_y = 1; c_score = 7; c_tlast = 0;
    repeat (5) @(posedge clk);
    #1;
    cfg_w = 3; cfg_start = 1;
    @(posedge clk); #1 cfg_start = 0;
    chk("mid_state", {busy, o_valid, n_frm_w, n_x, corner_cnt},
        {1'b1, 1'b1, 16'd16, 16'd6, 16'd1});
    rst_n = 0; #1;
    rst_chk("mid_rst");
    @(posedge clk); #1;
    up_valid = 0; n_ready = 0; c_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;
    rst_chk("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
